// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and sizes for the data-memory arbiter
package mem_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        VGA  = 2'd2
    } owner_e;

    localparam int DMEM_ADDR_W = 10;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/VGA arbiter for the single-port data memory
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int VGA_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [31:0]       vga_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(VGA_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(VGA_MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;
    logic             force_v;
    logic             gnt_v;
    logic             gnt_c;
    owner_e           rsp_owner_q;
    owner_e           rsp_owner_d;
    logic [31:0]      cpu_rdata_q;
    logic [31:0]      cpu_rdata_d;
    logic [31:0]      vga_rdata_q;
    logic [31:0]      vga_rdata_d;

    // Grants are suppressed while reset is held so the memory stays idle.
    assign force_v   = vga_req && (wait_cnt == WAIT_LIMIT);
    assign gnt_v     = rstn && vga_req && (!cpu_req || force_v);
    assign gnt_c     = rstn && cpu_req && !gnt_v;
    assign cpu_stall = cpu_req && !gnt_c;
    assign vga_gnt   = gnt_v;

    sat_counter #(
        .MAX (VGA_MAX_WAIT),
        .W   (CNT_W)
    ) u_wait_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (vga_req && !gnt_v),
        .clr  (!vga_req || gnt_v),
        .cnt  (wait_cnt)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_c) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (gnt_v) begin
            mem_en    = 1'b1;
            mem_addr  = vga_addr;
        end
    end

    // Read data passes straight through in the response cycle and is held afterwards.
    always_comb begin
        rsp_owner_d = NONE;
        if (gnt_c && !cpu_we) begin
            rsp_owner_d = CPU;
        end else if (gnt_v) begin
            rsp_owner_d = VGA;
        end
        cpu_rvalid  = (rsp_owner_q == CPU);
        vga_rvalid  = (rsp_owner_q == VGA);
        cpu_rdata   = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        vga_rdata   = vga_rvalid ? mem_rdata : vga_rdata_q;
        cpu_rdata_d = cpu_rdata;
        vga_rdata_d = vga_rdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_owner_q <= NONE;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            rsp_owner_q <= rsp_owner_d;
            cpu_rdata_q <= cpu_rdata_d;
            vga_rdata_q <= vga_rdata_d;
        end
    end

endmodule
